// File: rtl/path_delay_monitor.sv
//------------------------------------------------------------------------------
// Module  : path_delay_monitor
// Brief   : Launches a transition into a monitored path and averages the arrival
//           delay over NUM_SAMPLES runs. Optional PDM_MINMAX_EN adds min/max ports.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module path_delay_monitor #(
    parameter int CNT_W       = 16,
    parameter int NUM_SAMPLES = 8,
    parameter int SETTLE      = 16,
    parameter int TIMEOUT     = 1023,
    parameter int MARGIN      = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] golden_delay_i,
    input  logic             path_out_i,
    output logic             launch_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] delay_out_o,
    output logic             alarm_o,
`ifdef PDM_MINMAX_EN
    output logic [CNT_W-1:0] min_delay_o,
    output logic [CNT_W-1:0] max_delay_o,
`endif
    output logic             timeout_o
);

    localparam int c_LOG2N = $clog2(NUM_SAMPLES);
    localparam int c_IDX_W = (c_LOG2N > 0) ? c_LOG2N : 1;
    localparam int c_SUM_W = CNT_W + c_LOG2N;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_LAUNCH  = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic               sync1_q, sync2_q;
    logic               ref_q, ref_d;
    logic               launch_q, launch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_IDX_W-1:0] idx_q, idx_d;
    logic [c_SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]   golden_q, golden_d;
    logic [CNT_W-1:0]   delay_q, delay_d;
    logic               alarm_q, alarm_d;
    logic               timeout_q, timeout_d;

    logic               w_changed, w_settled, w_last, w_tmo, w_alarm;
    logic [CNT_W-1:0]   w_cnt_inc, w_avg;
    logic [c_SUM_W-1:0] w_sum_nxt;
    logic [CNT_W:0]     w_avg_x, w_gold_x;

    assign w_changed = (sync2_q != ref_q);
    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_settled = (cnt_q == CNT_W'(SETTLE - 1));
    assign w_last    = (idx_q == c_IDX_W'(NUM_SAMPLES - 1));
    assign w_tmo     = !w_changed && (w_cnt_inc == CNT_W'(TIMEOUT));
    assign w_sum_nxt = sum_q + c_SUM_W'(w_cnt_inc);
    assign w_avg     = CNT_W'(w_sum_nxt >> c_LOG2N);
    // One extra bit so golden + MARGIN and avg + MARGIN cannot wrap.
    assign w_avg_x   = {1'b0, w_avg};
    assign w_gold_x  = {1'b0, golden_q};

`ifdef PDM_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0] min_out_q, min_out_d, max_out_q, max_out_d;
    logic [CNT_W-1:0] w_min_nxt, w_max_nxt;

    assign w_min_nxt = (w_cnt_inc < min_q) ? w_cnt_inc : min_q;
    assign w_max_nxt = (w_cnt_inc > max_q) ? w_cnt_inc : max_q;
    assign w_alarm   = (w_avg_x > w_gold_x + (CNT_W+1)'(MARGIN)) ||
                       (w_avg_x + (CNT_W+1)'(MARGIN) < w_gold_x) ||
                       ((w_max_nxt - w_min_nxt) > CNT_W'(MARGIN));
`else
    assign w_alarm   = (w_avg_x > w_gold_x + (CNT_W+1)'(MARGIN)) ||
                       (w_avg_x + (CNT_W+1)'(MARGIN) < w_gold_x);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_SETTLE;
            S_SETTLE:  if (w_settled) state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_MEASURE;
            S_MEASURE: begin
                if (w_tmo) begin
                    state_d = S_REPORT;
                end else if (w_changed) begin
                    state_d = w_last ? S_REPORT : S_SETTLE;
                end
            end
            S_REPORT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ref_d     = ref_q;
        launch_d  = launch_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        golden_d  = golden_q;
        delay_d   = delay_q;
        alarm_d   = alarm_q;
        timeout_d = timeout_q;
`ifdef PDM_MINMAX_EN
        min_d     = min_q;
        max_d     = max_q;
        min_out_d = min_out_q;
        max_out_d = max_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    golden_d  = golden_delay_i;
                    sum_d     = '0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    delay_d   = '0;
                    alarm_d   = 1'b0;
                    timeout_d = 1'b0;
`ifdef PDM_MINMAX_EN
                    min_d     = '1;
                    max_d     = '0;
                    min_out_d = '0;
                    max_out_d = '0;
`endif
                end
            end
            S_SETTLE: begin
                cnt_d = w_cnt_inc;
                if (w_settled) begin
                    // The launch edge and the reference sample share this clock edge.
                    ref_d    = sync2_q;
                    launch_d = ~launch_q;
                    cnt_d    = '0;
                end
            end
            S_LAUNCH: cnt_d = '0;
            S_MEASURE: begin
                cnt_d = w_cnt_inc;
                if (w_tmo) begin
                    delay_d   = '1;
                    alarm_d   = 1'b1;
                    timeout_d = 1'b1;
`ifdef PDM_MINMAX_EN
                    min_out_d = '1;
                    max_out_d = '1;
`endif
                end else if (w_changed) begin
                    sum_d = w_sum_nxt;
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
`ifdef PDM_MINMAX_EN
                    min_d = w_min_nxt;
                    max_d = w_max_nxt;
`endif
                    if (w_last) begin
                        delay_d = w_avg;
                        alarm_d = w_alarm;
`ifdef PDM_MINMAX_EN
                        min_out_d = w_min_nxt;
                        max_out_d = w_max_nxt;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            ref_q     <= 1'b0;
            launch_q  <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            golden_q  <= '0;
            delay_q   <= '0;
            alarm_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef PDM_MINMAX_EN
            min_q     <= '0;
            max_q     <= '0;
            min_out_q <= '0;
            max_out_q <= '0;
`endif
        end else begin
            sync1_q   <= path_out_i;
            sync2_q   <= sync1_q;
            ref_q     <= ref_d;
            launch_q  <= launch_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            golden_q  <= golden_d;
            delay_q   <= delay_d;
            alarm_q   <= alarm_d;
            timeout_q <= timeout_d;
`ifdef PDM_MINMAX_EN
            min_q     <= min_d;
            max_q     <= max_d;
            min_out_q <= min_out_d;
            max_out_q <= max_out_d;
`endif
        end
    end

    always_comb begin
        busy_o      = (state_q == S_SETTLE) || (state_q == S_LAUNCH) || (state_q == S_MEASURE);
        done_o      = (state_q == S_REPORT);
        launch_o    = launch_q;
        delay_out_o = delay_q;
        alarm_o     = alarm_q;
        timeout_o   = timeout_q;
`ifdef PDM_MINMAX_EN
        min_delay_o = min_out_q;
        max_delay_o = max_out_q;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_path_delay_monitor.sv
//------------------------------------------------------------------------------
// Module  : tb_path_delay_monitor
// Brief   : Bench for path_delay_monitor with a polarity-dependent delay-line path.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_path_delay_monitor;

    localparam int CNT_W   = 16;
    localparam int N       = 8;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1023;
    localparam int MARGIN  = 2;
    localparam int BUDGET  = 5000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] golden = '0;
    logic             path_out;
    logic             launch, busy, done, alarm, tmo;
    logic [CNT_W-1:0] delay_out;
`ifdef PDM_MINMAX_EN
    logic [CNT_W-1:0] min_delay, max_delay;
`endif

    path_delay_monitor #(
        .CNT_W(CNT_W), .NUM_SAMPLES(N), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .MARGIN(MARGIN)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .golden_delay_i (golden),
        .path_out_i     (path_out),
        .launch_o       (launch),
        .busy_o         (busy),
        .done_o         (done),
        .delay_out_o    (delay_out),
        .alarm_o        (alarm),
`ifdef PDM_MINMAX_EN
        .min_delay_o    (min_delay),
        .max_delay_o    (max_delay),
`endif
        .timeout_o      (tmo)
    );

    always #5 clk = ~clk;

    // Path model: launch delayed by d_rise cycles after a rising launch, d_fall after a falling one.
    logic [31:0] hist = '0;
    int          d_rise = 0, d_fall = 0;
    bit          tie0 = 1'b0;
    int          d_sel;
    always @(posedge clk) hist <= {hist[30:0], launch};
    always @* begin
        d_sel = launch ? d_rise : d_fall;
        if (tie0)            path_out = 1'b0;
        else if (d_sel == 0) path_out = launch;
        else                 path_out = hist[d_sel-1];
    end

    int  vectors = 0, errors = 0;
    bit  m_launch = 1'b0;
    int  exp_delay, exp_alarm, exp_tmo, exp_min, exp_max;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_launch"}, 64'(launch), 64'd0);
        check({tag, "_busy"},   64'(busy),   64'd0);
        check({tag, "_done"},   64'(done),   64'd0);
        check({tag, "_delay"},  64'(delay_out), 64'd0);
        check({tag, "_alarm"},  64'(alarm),  64'd0);
        check({tag, "_tmo"},    64'(tmo),    64'd0);
`ifdef PDM_MINMAX_EN
        check({tag, "_min"},    64'(min_delay), 64'd0);
        check({tag, "_max"},    64'(max_delay), 64'd0);
`endif
    endtask

    // Reference: each run flips launch; arrival is path delay plus 2 synchroniser cycles.
    task automatic model(input int g, input bit timed_out);
        int sum, s, avg;
        if (timed_out) begin
            m_launch  = ~m_launch;
            exp_delay = 16'hFFFF; exp_alarm = 1; exp_tmo = 1;
            exp_min   = 16'hFFFF; exp_max   = 16'hFFFF;
        end else begin
            sum = 0; exp_min = 1 << 30; exp_max = 0;
            for (int i = 0; i < N; i++) begin
                m_launch = ~m_launch;
                s = (m_launch ? d_rise : d_fall) + 2;
                sum += s;
                if (s < exp_min) exp_min = s;
                if (s > exp_max) exp_max = s;
            end
            avg       = sum / N;
            exp_delay = avg;
            exp_alarm = ((avg > g + MARGIN) || (avg + MARGIN < g)) ? 1 : 0;
`ifdef PDM_MINMAX_EN
            if (exp_max - exp_min > MARGIN) exp_alarm = 1;
`endif
            exp_tmo = 0;
        end
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        golden = CNT_W'(g);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_delay"}, 64'(delay_out), 64'(exp_delay));
        check({tag, "_alarm"}, 64'(alarm),     64'(exp_alarm));
        check({tag, "_tmo"},   64'(tmo),       64'(exp_tmo));
        check({tag, "_busy"},  64'(busy),      64'd0);
`ifdef PDM_MINMAX_EN
        check({tag, "_min"},   64'(min_delay), 64'(exp_min));
        check({tag, "_max"},   64'(max_delay), 64'(exp_max));
`endif
    endtask

    task automatic measure(input string tag, input int g, input bit timed_out);
        bit ok;
        pulse_start(g);
        model(g, timed_out);
        wait_done(tag, ok);
        if (ok) begin
            check_results(tag);
            @(negedge clk);
            check({tag, "_done_once"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        bit ok;
        bit prev;
        int toggles, dones;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        d_rise = 0; d_fall = 0;
        measure("zero_delay", 2, 1'b0);

        d_rise = 5; d_fall = 5;
        measure("d5_g7", 7, 1'b0);
        measure("d5_g4", 4, 1'b0);

        d_rise = 5; d_fall = 9;
        measure("trojan", 7, 1'b0);

        tie0 = 1'b1;
        measure("timeout", 7, 1'b1);
        tie0 = 1'b0;

        // Reset while the third run is in flight.
        d_rise = 5; d_fall = 5;
        pulse_start(7);
        prev = launch; toggles = 0;
        for (int i = 0; i < BUDGET && toggles < 3; i++) begin
            @(negedge clk);
            if (launch != prev) begin
                toggles++;
                prev = launch;
            end
        end
        check("midrun_reached", 64'(toggles), 64'd3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("midrun_reset");
        m_launch = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (400) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrun_no_done", 64'(dones), 64'd0);
        measure("after_reset", 7, 1'b0);

        // start pulsed mid-run, then held high across REPORT.
        pulse_start(7);
        model(7, 1'b0);
        repeat (60) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        wait_done("held", ok);
        if (ok) begin
            check_results("held");
            @(negedge clk);
            check("held_idle_busy", 64'(busy), 64'd0);
            check("held_idle_done", 64'(done), 64'd0);
            @(negedge clk);
            check("held_restart_busy", 64'(busy), 64'd1);
            start = 1'b0;
            model(7, 1'b0);
            wait_done("held_second", ok);
            if (ok) check_results("held_second");
        end
        start = 1'b0;

        for (int k = 0; k < 4; k++) begin
            d_rise = int'($urandom_range(0, 12));
            d_fall = ($urandom_range(0, 1) == 0) ? d_rise : int'($urandom_range(0, 12));
            measure($sformatf("rand%0d", k), int'($urandom_range(0, 16)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
